// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: bus widths, general-call address
// and the target FSM state encoding.
package i2c_target_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;

    localparam logic [I2C_ADDR_W-1:0] GCALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } tgt_state_t;

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C bus condition detector: synchronizes SCL/SDA, detects SCL edges and
// START/STOP conditions. All outputs are registered and mutually aligned.
// Ports:
//   clk, rst        system clock, async active-high reset
//   scl_in, sda_in  raw bus levels
//   scl_rise/fall   one-cycle pulses on synced SCL edges
//   sda_s           synced SDA, aligned with the pulses
//   start_det       SDA fell while SCL high
//   stop_det        SDA rose while SCL high
module i2c_bus_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_now;
    logic                   sda_now;

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];

    // Reset to the idle-bus level (both high) so no false edge appears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_hist  <= 1'b1;
            sda_hist  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            sda_s     <= 1'b1;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist  <= scl_now;
            sda_hist  <= sda_now;
            scl_rise  <= scl_now & ~scl_hist;
            scl_fall  <= ~scl_now & scl_hist;
            sda_s     <= sda_now;
            start_det <= scl_now & scl_hist & sda_hist & ~sda_now;
            stop_det  <= scl_now & scl_hist & ~sda_hist & sda_now;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target. Oversamples the bus, matches TGT_ADDR, ACKs,
// delivers write bytes to the core and shifts core-supplied bytes out on
// reads. SDA is open-drain (sda_oe pulls low); SCL is never driven.
// Optional: define I2C_TGT_GCALL_EN to also ACK the general-call write
// address (8'h00).
// Ports:
//   clk, rst          system clock, async active-high reset
//   scl_in, sda_in    bus levels
//   sda_oe            1 = pull SDA low
//   rx_data/valid     received write byte and its one-cycle strobe
//   rx_first          with rx_valid: first data byte after the address
//   tx_data, tx_req   core read byte, sampled in the cycle tx_req is high
//   busy              addressed transaction in progress
//   stop_det          one-cycle pulse on any bus STOP
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TGT_ADDR    = 7'h50,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_first,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  busy,
    output logic                  stop_det
);

    logic scl_rise, scl_fall, sda_s, bus_start, bus_stop;

    i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_bus_cond (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (bus_start),
        .stop_det  (bus_stop)
    );

    tgt_state_t            state;
    logic [2:0]            bit_cnt;
    logic [I2C_BYTE_W-1:0] shreg;
    logic [I2C_BYTE_W-1:0] shift_in;
    logic                  rw;
    logic                  first_byte;
    logic                  rd_acked;
    logic                  addr_hit;

    assign shift_in = {shreg[I2C_BYTE_W-2:0], sda_s};

    // Address decode on the complete address byte (address + R/W)
    always_comb begin
        addr_hit = (shift_in[I2C_BYTE_W-1:1] == TGT_ADDR);
`ifdef I2C_TGT_GCALL_EN
        if (shift_in == {GCALL_ADDR, 1'b0}) addr_hit = 1'b1;
`endif
    end

    // Target FSM; ACK phases use sda_oe itself to tell the opening fall
    // (drive low) from the closing fall (release / first read bit).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= '0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            rd_acked   <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            tx_req     <= 1'b0;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            tx_req   <= 1'b0;
            stop_det <= 1'b0;
            if (bus_stop) begin
                state    <= ST_IDLE;
                bit_cnt  <= 3'd0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                rd_acked <= 1'b0;
                stop_det <= 1'b1;
            end else if (bus_start) begin
                state    <= ST_ADDR;
                bit_cnt  <= 3'd0;
                sda_oe   <= 1'b0;
                rd_acked <= 1'b0;
            end else begin
                // Core byte arrives the cycle after tx_req was raised
                if (tx_req) begin
                    shreg <= tx_data;
                    if (state == ST_RD_DATA) sda_oe <= ~tx_data[I2C_BYTE_W-1];
                end
                case (state)
                    ST_IDLE: ;
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw <= sda_s;
                                if (addr_hit) begin
                                    state <= ST_ADDR_ACK;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                                tx_req <= rw;
                            end else begin
                                bit_cnt <= 3'd0;
                                if (rw) begin
                                    sda_oe <= ~shreg[I2C_BYTE_W-1];
                                    state  <= ST_RD_DATA;
                                end else begin
                                    sda_oe     <= 1'b0;
                                    first_byte <= 1'b1;
                                    state      <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data    <= shift_in;
                                rx_valid   <= 1'b1;
                                rx_first   <= first_byte;
                                first_byte <= 1'b0;
                                state      <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rd_acked <= 1'b0;
                                state    <= ST_RD_ACK;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= ~shreg[I2C_BYTE_W-2];
                            shreg  <= {shreg[I2C_BYTE_W-2:0], 1'b0};
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) rd_acked <= 1'b1;
                            else        state    <= ST_WAIT_STOP;
                        end else if (scl_fall) begin
                            if (rd_acked) begin
                                tx_req   <= 1'b1;
                                rd_acked <= 1'b0;
                                bit_cnt  <= 3'd0;
                                state    <= ST_RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_WAIT_STOP: sda_oe <= 1'b0;
                    default:      state  <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed self-checking bench for i2c_target: a bit-banged I2C controller
// drives SCL/SDA (SDA wired-AND with the target's pull-down) and monitors
// count the target's strobes.
module tb_i2c_target;

    localparam int unsigned Q = 8;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv;
    logic       sda_drv;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       stop_det;

    logic [7:0]  txq [0:7];
    int unsigned tx_idx   = 0;
    int unsigned rxv_cnt  = 0;
    int unsigned txr_cnt  = 0;
    int unsigned stop_cnt = 0;
    int unsigned oe_cnt   = 0;
    int unsigned hi_viol  = 0;
    logic        last_first = 1'b0;
    logic        oe_q  = 1'b0;
    logic        scl_q = 1'b1;

    int n_vec  = 0;
    int n_fail = 0;

    assign sda_bus = sda_drv & ~sda_oe;
    assign tx_data = txq[3'(tx_idx)];

    always #5 clk = ~clk;

    i2c_target dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_drv),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .stop_det (stop_det)
    );

    // Strobe counters and SDA-change-while-SCL-high watchdog
    always @(posedge clk) begin
        oe_q  <= sda_oe;
        scl_q <= scl_drv;
        if (rx_valid) begin
            rxv_cnt    <= rxv_cnt + 1;
            last_first <= rx_first;
        end
        if (tx_req) begin
            txr_cnt <= txr_cnt + 1;
            tx_idx  <= tx_idx + 1;
        end
        if (stop_det) stop_cnt <= stop_cnt + 1;
        if (sda_oe)   oe_cnt   <= oe_cnt + 1;
        if (!rst && (sda_oe != oe_q) && scl_drv && scl_q) hi_viol <= hi_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        sda_drv = 1'b1; wq(Q);
        scl_drv = 1'b1; wq(Q);
        sda_drv = 1'b0; wq(Q);
        scl_drv = 1'b0; wq(Q);
    endtask

    task automatic bus_stop;
        sda_drv = 1'b0; wq(Q);
        scl_drv = 1'b1; wq(Q);
        sda_drv = 1'b1; wq(Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_drv = b;    wq(Q);
        scl_drv = 1'b1; wq(Q);
        s = sda_bus;    wq(Q);
        scl_drv = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(ack, s);
    endtask

    initial begin
        logic        ack;
        logic        s;
        logic [7:0]  d;
        logic [2:0]  ti;
        int unsigned rxv0, txr0, stop0, oe0;
        logic        exp_ack;
        int unsigned exp_rxv;

        for (int i = 0; i < 8; i++) txq[i] = 8'h00;
        rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
        wq(4);
        check("rst_sda_oe",   32'(sda_oe),   32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_req",   32'(tx_req),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_stop_det", 32'(stop_det), 32'd0);
        rst = 1'b0;
        wq(2 * Q);

        // Write to own address
        rxv0 = rxv_cnt; stop0 = stop_cnt;
        bus_start;
        write_byte(8'hA0, ack); check("wr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h3C, ack); check("wr_data_ack", 32'(ack), 32'd0);
        check("wr_busy",     32'(busy),          32'd1);
        check("wr_rx_count", rxv_cnt - rxv0,     32'd1);
        check("wr_rx_data",  32'(rx_data),       32'h3C);
        check("wr_rx_first", 32'(last_first),    32'd1);
        bus_stop;
        wq(Q);
        check("wr_stop_det", stop_cnt - stop0,   32'd1);
        check("wr_busy_end", 32'(busy),          32'd0);

        // Address mismatch
        rxv0 = rxv_cnt; txr0 = txr_cnt; oe0 = oe_cnt; stop0 = stop_cnt;
        bus_start;
        write_byte(8'hA2, ack); check("mm_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h55, ack); check("mm_data_nack", 32'(ack), 32'd1);
        bus_stop;
        wq(Q);
        check("mm_oe_cycles", oe_cnt - oe0,     32'd0);
        check("mm_rx_count",  rxv_cnt - rxv0,   32'd0);
        check("mm_tx_count",  txr_cnt - txr0,   32'd0);
        check("mm_stop_det",  stop_cnt - stop0, 32'd1);
        check("mm_busy",      32'(busy),        32'd0);

        // Read two bytes: controller ACKs the first, NACKs the second
        ti = 3'(tx_idx);
        txq[ti] = 8'hA5; txq[ti + 3'd1] = 8'h0F;
        txr0 = txr_cnt;
        bus_start;
        write_byte(8'hA1, ack); check("rd_addr_ack", 32'(ack), 32'd0);
        check("rd_busy", 32'(busy), 32'd1);
        read_byte(1'b0, d); check("rd_byte0", 32'(d), 32'hA5);
        read_byte(1'b1, d); check("rd_byte1", 32'(d), 32'h0F);
        check("rd_release", 32'(sda_oe),     32'd0);
        check("rd_tx_count", txr_cnt - txr0, 32'd2);
        bus_stop;
        wq(Q);

        // Write then repeated START into a read
        ti = 3'(tx_idx);
        txq[ti] = 8'h5A;
        rxv0 = rxv_cnt; txr0 = txr_cnt;
        bus_start;
        write_byte(8'hA0, ack); check("sr_wr_ack",   32'(ack), 32'd0);
        write_byte(8'h11, ack); check("sr_data_ack", 32'(ack), 32'd0);
        check("sr_rx_data",  32'(rx_data),    32'h11);
        check("sr_rx_first", 32'(last_first), 32'd1);
        bus_start;
        write_byte(8'hA1, ack); check("sr_rd_ack", 32'(ack), 32'd0);
        check("sr_tx_after_addr", txr_cnt - txr0, 32'd1);
        read_byte(1'b1, d); check("sr_rd_byte", 32'(d), 32'h5A);
        check("sr_rx_count", rxv_cnt - rxv0, 32'd1);
        bus_stop;
        wq(Q);

        // Reset in the middle of a data byte
        rxv0 = rxv_cnt;
        bus_start;
        write_byte(8'hA0, ack); check("mr_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        rst = 1'b1;
        #1;
        check("mr_sda_oe", 32'(sda_oe), 32'd0);
        check("mr_busy",   32'(busy),   32'd0);
        wq(3);
        rst = 1'b0;
        wq(2 * Q);
        bus_start;
        write_byte(8'hA0, ack); check("mr_again_ack", 32'(ack), 32'd0);
        bus_stop;
        wq(Q);
        check("mr_rx_count", rxv_cnt - rxv0, 32'd0);

        // General call write
`ifdef I2C_TGT_GCALL_EN
        exp_ack = 1'b0; exp_rxv = 1;
`else
        exp_ack = 1'b1; exp_rxv = 0;
`endif
        rxv0 = rxv_cnt;
        bus_start;
        write_byte(8'h00, ack); check("gc_addr_ack", 32'(ack), 32'(exp_ack));
        write_byte(8'h77, ack); check("gc_data_ack", 32'(ack), 32'(exp_ack));
        check("gc_rx_count", rxv_cnt - rxv0, exp_rxv);
`ifdef I2C_TGT_GCALL_EN
        check("gc_rx_data",  32'(rx_data),    32'h77);
        check("gc_rx_first", 32'(last_first), 32'd1);
`endif
        bus_stop;
        wq(Q);

        check("sda_change_scl_high", hi_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (slave): the responder end of the I2C controller bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches its own address, ACKs, delivers received write bytes to the core and shifts core-supplied bytes out on reads.
- Drives SDA open-drain only (pull-low enable); never drives SCL; no clock stretching.

Parameters:
- TGT_ADDR, 7'h50, own 7-bit bus address
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (min 2)

Ports:
- clk  in  1  system clock, ≥8× SCL frequency
- rst  in  1  asynchronous, active-high reset
- scl_in  in  1  bus SCL level
- sda_in  in  1  bus SDA level
- sda_oe  out  1  1 = pull SDA low, 0 = release
- rx_data  out  8  last received write byte
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_first  out  1  qualifies rx_valid: first data byte after address
- tx_data  in  8  next read byte; sampled in the cycle tx_req is high
- tx_req  out  1  one-cycle pulse, core must present tx_data this cycle
- busy  out  1  addressed transaction in progress
- stop_det  out  1  one-cycle pulse on any bus STOP

Behaviour:
- Reset (async, rst=1): state IDLE; sda_oe=0; rx_data=0; rx_valid, rx_first, tx_req, busy, stop_det = 0; bit counter 0.
- Inputs pass through SYNC_STAGES flops plus one history flop.
  - SCL rise/fall = change of the synced SCL.
  - START = synced SDA falls while SCL high.
  - STOP = synced SDA rises while SCL high.
- SDA sampling: on detected SCL rise, MSB first.
- sda_oe changes only in the clk cycle after a detected SCL fall; it is never changed while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE: on START → ADDR, counter=0.
- ADDR: shift 8 bits (7 address + R/W).
  - After the 8th rise: address match → ADDR_ACK.
  - Mismatch → WAIT_STOP; sda_oe stays 0.
- ADDR_ACK: sda_oe=1 from the next SCL fall until the following SCL fall; busy=1.
  - R/W=0 → WR_DATA.
  - R/W=1 → RD_DATA. tx_req pulses on the SCL fall that starts the ACK bit; tx_data is loaded into the shift register; bit 7 is driven at the fall ending the ACK.
- WR_DATA: 8 rises → rx_data updated and rx_valid pulses 1 clk after the 8th rise. rx_first=1 only for the first byte after the address. Then → WR_ACK.
- WR_ACK: target always ACKs (sda_oe=1 for one SCL period) → WR_DATA.
- RD_DATA: sda_oe = ~bit for each bit, updated after each SCL fall. After the 8th bit, release SDA at the next fall → RD_ACK.
- RD_ACK: sample SDA on the 9th rise.
  - 0 (controller ACK) → tx_req pulse at the next fall, load byte → RD_DATA.
  - 1 (NACK) → WAIT_STOP, SDA released.
- WAIT_STOP: SDA released; ignore bits until STOP or START.
- Priority:
  - STOP in any state → IDLE, sda_oe=0, busy=0, stop_det pulse.
  - START (repeated) in any state → ADDR, counter=0, sda_oe=0; busy holds until address decided.
  - STOP/START take precedence over a same-cycle SCL edge.
- Reset mid-byte: immediate release of SDA and return to IDLE; partial byte is discarded, no rx_valid.
- Counter is 3 bits and wraps 7→0 at each byte boundary; no overflow path.

Optional Feature:
- Macro: I2C_TGT_GCALL_EN.
- Defined: address byte 8'h00 (general call, write) is ACKed and treated as a write with rx_first=1. Address 0 with R/W=1 is NACKed → WAIT_STOP.
- Undefined: only TGT_ADDR matches; 8'h00 → WAIT_STOP, no ACK.

Decomposition:
- Shared package holds:
  - State enumeration constants for the target FSM.
  - I2C_ADDR_W=7, I2C_BYTE_W=8.
  - GCALL_ADDR=7'h00.
- One sub-module: i2c_bus_cond. It contains the synchronizers, edge detect and START/STOP detect, and outputs scl_rise, scl_fall, sda_s, start_det and stop_det pulses.
- The FSM, shift registers and handshake logic stay in i2c_target.

Test Plan:
- Write, matching address: START, 0xA0, 0x3C, STOP → ACK on bit 9 of both bytes; rx_valid once with rx_data=0x3C, rx_first=1; stop_det pulses; busy 0 after STOP.
- Address mismatch: START, 0xA2, 0x55, STOP → sda_oe stays 0 throughout; no rx_valid; no tx_req.
- Read two bytes: START, 0xA1; tx_data=0xA5 then 0x0F; controller ACK then NACK.
  - SDA bits 1010_0101 then 0000_1111.
  - tx_req pulses exactly twice.
  - SDA released after the NACK.
- Repeated START: write 0xA0, 0x11, then Sr + 0xA1 → rx_data=0x11 delivered; then read proceeds with tx_req after the address ACK.
- Reset mid-byte: assert rst after 4 bits of a data byte → sda_oe=0 immediately; no rx_valid; next START + 0xA0 is ACKed normally.
- Macro on/off: START, 0x00, 0x77, STOP → with macro: ACK and rx_data=0x77, rx_first=1; without macro: no ACK, no rx_valid.
